// File: rtl/counter_ex_pkg.sv
// Shared constants and the next-value function for counter_ex.
// The function works at MAX_W bits; callers zero-extend q/limit and truncate the result.
package counter_ex_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] ONE  = {{(MAX_W-1){1'b0}}, 1'b1};
    localparam logic [MAX_W-1:0] ZERO = '0;

    typedef struct packed {
        logic [MAX_W-1:0] q;
        logic             ovf;
    } step_t;

    // Compare happens before the increment, so q+1 never exceeds limit.
    function automatic step_t counter_next(input logic [MAX_W-1:0] q,
                                           input logic [MAX_W-1:0] limit,
                                           input logic             dir,
                                           input logic             sat);
        step_t r;
        r.q   = q;
        r.ovf = 1'b0;
        if (dir == DIR_UP) begin
            if (q < limit) begin
                r.q = q + ONE;
            end else begin
                r.q   = (sat == MODE_SAT) ? limit : ZERO;
                r.ovf = 1'b1;
            end
        end else begin
            if (q > limit) begin
                // limit was lowered under a running count: snap down, no event
                r.q = limit;
            end else if (q != ZERO) begin
                r.q = q - ONE;
            end else begin
                r.q   = (sat == MODE_SAT) ? ZERO : limit;
                r.ovf = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Rate gate for counter_ex: tick once per (presc+1) enabled cycles.
// Count restarts at 0 on clr so the first enabled cycle afterwards ticks.
module counter_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] presc,
    output logic          tick
);

    logic [PW-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? presc : cnt - {{(PW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/counter_ex.sv
// Up/down counter with load, programmable limit, wrap/saturate and ovf pulse.
// Optional prescaler compiled in with COUNTER_EX_PRESCALE_EN.
module counter_ex
    import counter_ex_pkg::*;
#(
    parameter int W  = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          sclrn,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [W-1:0]  d,
    input  logic [W-1:0]  limit,
    input  logic          sat,
    input  logic [PW-1:0] presc,
    output logic [W-1:0]  q,
    output logic          ovf,
    output logic          at_zero,
    output logic          at_limit
);

    logic  tick;
    step_t nx;

    always_comb begin
        nx = counter_next(MAX_W'(q), MAX_W'(limit), dir, sat);
    end

`ifdef COUNTER_EX_PRESCALE_EN
    counter_prescaler #(.PW(PW)) u_presc (
        .clk   (clk),
        .clrn  (clrn),
        .clr   (!sclrn || load),
        .en    (en),
        .presc (presc),
        .tick  (tick)
    );
    logic unused_ok;
    assign unused_ok = &{1'b0, nx};
`else
    assign tick = 1'b1;
    logic unused_ok;
    assign unused_ok = &{1'b0, nx, presc};
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (!sclrn) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= (d > limit) ? limit : d;
            ovf <= 1'b0;
        end else if (en && tick) begin
            q   <= nx.q[W-1:0];
            ovf <= nx.ovf;
        end else begin
            ovf <= 1'b0;
        end
    end

    assign at_zero  = (q == '0);
    assign at_limit = (q == limit);

endmodule

// File: tb/tb_counter_ex.sv
// Directed bench for counter_ex with hand-computed expected values.
module tb_counter_ex;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk, clrn, sclrn, en, dir, load, sat;
    logic [W-1:0]  d, limit, q;
    logic [PW-1:0] presc;
    logic          ovf, at_zero, at_limit;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q1 [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    logic       exp_o1 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_q2 [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       exp_o2 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef COUNTER_EX_PRESCALE_EN
    logic [7:0] exp_qp [10] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4};
    logic [7:0] exp_qr [3]  = '{8'd4, 8'd4, 8'd5};
`endif

    counter_ex #(.W(W), .PW(PW)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .sclrn    (sclrn),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .d        (d),
        .limit    (limit),
        .sat      (sat),
        .presc    (presc),
        .q        (q),
        .ovf      (ovf),
        .at_zero  (at_zero),
        .at_limit (at_limit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] val, input logic [W-1:0] lim);
        load  = 1'b1;
        d     = val;
        limit = lim;
        en    = 1'b0;
        cyc();
        load  = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; sclrn = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0;
        sat = 1'b0; d = '0; limit = 8'd5; presc = '0;
        #1;
        check("rst_q", q, 0);
        check("rst_ovf", ovf, 0);
        check("rst_at_zero", at_zero, 1);
        check("rst_at_limit_l5", at_limit, 0);
        limit = 8'd0;
        #1;
        check("rst_at_limit_l0", at_limit, 1);
        limit = 8'd5;
        #1;
        clrn = 1'b1;
        en   = 1'b1;

        // up, wrap, limit 5
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("up_wrap_q", q, exp_q1[i]);
            check("up_wrap_ovf", ovf, exp_o1[i]);
            check("up_wrap_at_limit", at_limit, (i == 4) ? 1 : 0);
        end
        en = 1'b0;

        // down, saturate from 2
        do_load(8'd2, 8'd5);
        check("load2_q", q, 2);
        dir = 1'b0; sat = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("down_sat_q", q, exp_q2[i]);
            check("down_sat_ovf", ovf, exp_o2[i]);
        end
        en = 1'b0;
        check("down_sat_at_zero", at_zero, 1);

        // load clamps to limit; load beats step
        do_load(8'd200, 8'd100);
        check("load_clamp_q", q, 100);
        check("load_clamp_at_limit", at_limit, 1);
        check("load_clamp_ovf", ovf, 0);
        load = 1'b1; d = 8'd7; en = 1'b1; dir = 1'b1;
        cyc();
        load = 1'b0; en = 1'b0;
        check("load_vs_step_q", q, 7);
        check("load_vs_step_ovf", ovf, 0);

        // limit lowered below a running count
        do_load(8'd50, 8'd255);
        limit = 8'd20; sat = 1'b0; dir = 1'b1; en = 1'b1;
        cyc(); en = 1'b0;
        check("lowlim_up_wrap_q", q, 0);
        check("lowlim_up_wrap_ovf", ovf, 1);
        do_load(8'd50, 8'd255);
        limit = 8'd20; sat = 1'b1; dir = 1'b1; en = 1'b1;
        cyc(); en = 1'b0;
        check("lowlim_up_sat_q", q, 20);
        check("lowlim_up_sat_ovf", ovf, 1);
        do_load(8'd50, 8'd255);
        limit = 8'd20; sat = 1'b0; dir = 1'b0; en = 1'b1;
        cyc(); en = 1'b0;
        check("lowlim_down_q", q, 20);
        check("lowlim_down_ovf", ovf, 0);

        // down wrap at 0, then ovf is a single-cycle pulse
        do_load(8'd0, 8'd5);
        dir = 1'b0; sat = 1'b0; en = 1'b1;
        cyc(); en = 1'b0;
        check("down_wrap_q", q, 5);
        check("down_wrap_ovf", ovf, 1);
        cyc();
        check("hold_q", q, 5);
        check("hold_ovf", ovf, 0);

        // limit 0
        limit = 8'd0; dir = 1'b0; en = 1'b1;
        cyc();
        check("lim0_snap_q", q, 0);
        check("lim0_snap_ovf", ovf, 0);
        cyc();
        check("lim0_down_q", q, 0);
        check("lim0_down_ovf", ovf, 1);
        dir = 1'b1;
        cyc();
        en = 1'b0;
        check("lim0_up_q", q, 0);
        check("lim0_up_ovf", ovf, 1);
        check("lim0_at_limit", at_limit, 1);

        // sync clear beats load and clears a pending ovf
        do_load(8'd3, 8'd3);
        sat = 1'b1; dir = 1'b1; en = 1'b1;
        cyc();
        check("sat_top_q", q, 3);
        check("sat_top_ovf", ovf, 1);
        sclrn = 1'b0; load = 1'b1; d = 8'd9;
        cyc();
        sclrn = 1'b1; load = 1'b0; en = 1'b0;
        check("sclr_q", q, 0);
        check("sclr_ovf", ovf, 0);

        // async clear mid-cycle
        do_load(8'd3, 8'd3);
        sat = 1'b1; dir = 1'b1; en = 1'b1;
        cyc();
        check("pre_aclr_ovf", ovf, 1);
        #2 clrn = 1'b0;
        #1;
        check("aclr_q", q, 0);
        check("aclr_ovf", ovf, 0);
        check("aclr_at_zero", at_zero, 1);
        #2 clrn = 1'b1;
        sat = 1'b0;
        cyc();
        en = 1'b0;
        check("post_aclr_q", q, 1);
        check("post_aclr_ovf", ovf, 0);

`ifdef COUNTER_EX_PRESCALE_EN
        sclrn = 1'b0; presc = 4'd2; limit = 8'd255;
        cyc();
        sclrn = 1'b1; dir = 1'b1; sat = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("presc_q", q, exp_qp[i]);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("presc_frozen_q", q, 4);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("presc_resume_q", q, exp_qr[i]);
        end
        en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
